// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 core slice.
package ysyx_24080006_pkg;

  localparam int REG_WIDTH = 4;

  typedef logic [1:0] scoreboard_cnt_t;

endpackage

// File: rtl/ysyx_24080006_scoreboard.sv
// Register scoreboard: tracks outstanding GPR writes, stalls or bypasses
// hazardous sources at issue, and counts stalled issue cycles.
module ysyx_24080006_scoreboard
  import ysyx_24080006_pkg::scoreboard_cnt_t;
#(
  parameter int REG_WIDTH    = ysyx_24080006_pkg::REG_WIDTH,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_WIDTH-1:0] issue_rs1,
  input  logic [REG_WIDTH-1:0] issue_rs2,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 issue_rs1_used,
  input  logic                 issue_rs2_used,
  input  logic                 issue_rd_we,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [31:0]          wb_data,
  input  logic                 flush,
  output logic                 fwd_rs1_en,
  output logic                 fwd_rs2_en,
  output logic [31:0]          fwd_data,
  output logic [1:0]           inflight,
  output logic [31:0]          stall_cnt,
  output logic                 wb_err
);

  localparam int         NUM_REGS  = 1 << REG_WIDTH;
  localparam logic [1:0] MAX_LIMIT = 2'(MAX_INFLIGHT);

  // Two bits per register, register i at bits [2i+1:2i].
  logic [2*NUM_REGS-1:0] cnt_q, cnt_d;
  logic [1:0]            inflight_d;

  function automatic scoreboard_cnt_t cnt_of(input logic [REG_WIDTH-1:0] idx);
    return cnt_q[{idx, 1'b0} +: 2];
  endfunction

  scoreboard_cnt_t rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic rs1_haz, rs2_haz, rs1_fwd, rs2_fwd;
  logic wb_hit, wb_bad, rd_track, rd_block, issue_fire;

  assign rs1_cnt = cnt_of(issue_rs1);
  assign rs2_cnt = cnt_of(issue_rs2);
  assign rd_cnt  = cnt_of(issue_rd);
  assign wb_cnt  = cnt_of(wb_rd);

  assign rs1_haz = issue_rs1_used && (issue_rs1 != '0) && (rs1_cnt != 2'd0);
  assign rs2_haz = issue_rs2_used && (issue_rs2 != '0) && (rs2_cnt != 2'd0);

  // Only the last outstanding write may be bypassed from the writeback port.
  assign rs1_fwd = rs1_haz && (rs1_cnt == 2'd1) && wb_valid && (wb_rd == issue_rs1);
  assign rs2_fwd = rs2_haz && (rs2_cnt == 2'd1) && wb_valid && (wb_rd == issue_rs2);

  assign wb_hit = wb_valid && (wb_rd != '0) && (wb_cnt != 2'd0);
  assign wb_bad = wb_valid && (wb_rd != '0) && (wb_cnt == 2'd0);

  assign rd_track = issue_rd_we && (issue_rd != '0);
  assign rd_block = rd_track && (((inflight == MAX_LIMIT) && !wb_hit) || (rd_cnt == 2'd3));

  assign issue_ready = !flush && !(rs1_haz && !rs1_fwd) && !(rs2_haz && !rs2_fwd) && !rd_block;
  assign issue_fire  = issue_valid && issue_ready && rd_track;

  assign fwd_rs1_en = rs1_fwd;
  assign fwd_rs2_en = rs2_fwd;
  assign fwd_data   = (rs1_fwd || rs2_fwd) ? wb_data : 32'd0;

  always_comb begin
    // NOTE: defaults first so every path assigns cnt_d/inflight_d -- no latch.
    cnt_d      = cnt_q;
    inflight_d = inflight;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_fire && (issue_rd == REG_WIDTH'(i)) && !(wb_hit && (wb_rd == REG_WIDTH'(i))))
        cnt_d[2*i +: 2] = cnt_q[2*i +: 2] + 2'd1;
      else if (wb_hit && (wb_rd == REG_WIDTH'(i)) && !(issue_fire && (issue_rd == REG_WIDTH'(i))))
        cnt_d[2*i +: 2] = cnt_q[2*i +: 2] - 2'd1;
    end
    case ({issue_fire, wb_hit})
      2'b10:   inflight_d = inflight + 2'd1;
      2'b01:   inflight_d = inflight - 2'd1;
      default: inflight_d = inflight;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see
  // pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      inflight  <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt + 32'(issue_valid && !issue_ready);
      wb_err    <= wb_bad;
      if (flush) begin
        cnt_q    <= '0;
        inflight <= '0;
      end else begin
        cnt_q    <= cnt_d;
        inflight <= inflight_d;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_scoreboard.sv
// Directed self-checking bench for ysyx_24080006_scoreboard.
module tb_ysyx_24080006_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        fwd_rs1_en, fwd_rs2_en;
  logic [31:0] fwd_data;
  logic [1:0]  inflight;
  logic [31:0] stall_cnt;
  logic        wb_err;

  int checks_total  = 0;
  int checks_passed = 0;

  ysyx_24080006_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd_we(issue_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .fwd_rs1_en(fwd_rs1_en), .fwd_rs2_en(fwd_rs2_en), .fwd_data(fwd_data),
    .inflight(inflight), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      checks_passed++;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_we = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_wr(input logic [3:0] rd);
    idle();
    issue_valid = 1; issue_rd_we = 1; issue_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    // Ready during reset with no hazard; the issue must not be recorded.
    issue_wr(4'd5);
    #1 check("rst_ready", 32'(issue_ready), 1);
    step();
    step();
    check("rst_inflight", 32'(inflight), 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_wb_err", 32'(wb_err), 0);
    reset = 0;

    // RAW hazard on rs1 = 5 stalls with no writeback.
    issue_wr(4'd5);
    #1 check("rd5_ready", 32'(issue_ready), 1);
    step();
    check("rd5_inflight", 32'(inflight), 1);
    idle(); issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
    #1 check("raw_ready", 32'(issue_ready), 0);
    check("raw_nofwd", 32'(fwd_rs1_en), 0);
    step();
    check("stall_1", stall_cnt, 1);
    step();
    check("stall_2", stall_cnt, 2);

    // Same-cycle writeback bypass on rs2.
    idle(); issue_valid = 1; issue_rs2 = 5; issue_rs2_used = 1;
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    #1 check("byp_ready", 32'(issue_ready), 1);
    check("byp_rs2_en", 32'(fwd_rs2_en), 1);
    check("byp_rs1_en", 32'(fwd_rs1_en), 0);
    check("byp_data", fwd_data, 32'hDEADBEEF);
    step();
    check("byp_inflight", 32'(inflight), 0);
    check("byp_stall", stall_cnt, 2);

    // Fill to MAX_INFLIGHT, then a fourth write waits for a writeback.
    for (int r = 1; r <= 3; r++) begin
      issue_wr(4'(r));
      #1 check("fill_ready", 32'(issue_ready), 1);
      step();
    end
    check("full_inflight", 32'(inflight), 3);
    issue_wr(4'd4);
    #1 check("full_ready", 32'(issue_ready), 0);
    step();
    check("full_stall", stall_cnt, 3);
    wb_valid = 1; wb_rd = 1;
    #1 check("full_wb_ready", 32'(issue_ready), 1);
    step();
    check("full_wb_inflight", 32'(inflight), 3);

    idle(); wb_valid = 1; wb_rd = 2;
    step();
    check("two_inflight", 32'(inflight), 2);

    // Flush beats a simultaneous issue; a later writeback is untracked.
    issue_wr(4'd6); flush = 1;
    #1 check("flush_ready", 32'(issue_ready), 0);
    step();
    check("flush_inflight", 32'(inflight), 0);
    check("flush_stall", stall_cnt, 4);
    idle(); wb_valid = 1; wb_rd = 1;
    step();
    check("wb_err_set", 32'(wb_err), 1);
    check("wb_err_inflight", 32'(inflight), 0);
    idle(); issue_valid = 1; issue_rs1 = 3; issue_rs1_used = 1;
    #1 check("post_flush_ready", 32'(issue_ready), 1);
    step();
    check("wb_err_clear", 32'(wb_err), 0);

    // Register 0 is never a hazard nor tracked.
    issue_wr(4'd7);
    step();
    check("r7_inflight", 32'(inflight), 1);
    idle(); issue_valid = 1; issue_rs1 = 0; issue_rs1_used = 1;
    issue_rs2 = 0; issue_rs2_used = 1; issue_rd = 0; issue_rd_we = 1;
    #1 check("r0_ready", 32'(issue_ready), 1);
    check("r0_nofwd", 32'(fwd_rs1_en), 0);
    step();
    check("r0_inflight", 32'(inflight), 1);

    // Counter of 2 cannot be bypassed by one writeback.
    issue_wr(4'd7);
    step();
    check("r7x2_inflight", 32'(inflight), 2);
    idle(); issue_valid = 1; issue_rs1 = 7; issue_rs1_used = 1;
    wb_valid = 1; wb_rd = 7; wb_data = 32'h12345678;
    #1 check("cnt2_ready", 32'(issue_ready), 0);
    check("cnt2_nofwd", 32'(fwd_rs1_en), 0);
    check("cnt2_data", fwd_data, 0);
    step();
    check("cnt2_inflight", 32'(inflight), 1);
    check("cnt2_stall", stall_cnt, 5);

    // Mid-operation reset drops pending state quietly.
    idle(); reset = 1;
    step();
    reset = 0;
    check("mrst_inflight", 32'(inflight), 0);
    check("mrst_stall", stall_cnt, 0);
    check("mrst_wb_err", 32'(wb_err), 0);
    wb_valid = 1; wb_rd = 7;
    step();
    check("mrst_untracked", 32'(wb_err), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_scoreboard.md
YSYX_24080006_SCOREBOARD -- requirements
Module: ysyx_24080006_scoreboard

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 4: register index width (RV32E, 16 GPRs).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 3: maximum outstanding register writes, summed over all registers.
REQ-003 SHALL have port clock  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports issue_valid  in  1, issue_ready  out  1: issue handshake from decode to execute.
REQ-006 SHALL have ports issue_rs1, issue_rs2, issue_rd  in  REG_WIDTH each: source and destination indices of the issuing instruction.
REQ-007 SHALL have ports issue_rs1_used, issue_rs2_used, issue_rd_we  in  1 each: source read and destination write qualifiers.
REQ-008 SHALL have ports wb_valid  in  1, wb_rd  in  REG_WIDTH, wb_data  in  32: writeback event.
REQ-009 SHALL have port flush  in  1: pipeline flush; discards all tracking.
REQ-010 SHALL have ports fwd_rs1_en, fwd_rs2_en  out  1 and fwd_data  out  32: bypass selects and bypass value.
REQ-011 SHALL have ports inflight  out  2 and stall_cnt  out  32: outstanding-write count and stall performance counter.
REQ-012 SHALL have port wb_err  out  1: writeback to an untracked register, registered.

Function
REQ-013 SHALL hold one 2-bit pending counter per register; register 0 is never tracked, never stalls, and never forwards.
REQ-014 SHALL treat a source as hazardous when its used flag is 1 and its pending counter is non-zero.
REQ-015 SHALL resolve a hazardous source in the same cycle when the counter is 1, wb_valid is 1, and wb_rd equals the source: fwd_rsN_en = 1 and fwd_data = wb_data (combinational).
REQ-016 SHALL deassert issue_ready when any hazardous source is not resolved under REQ-015.
REQ-017 SHALL deassert issue_ready when issue_rd_we = 1, issue_rd != 0, and either inflight = MAX_INFLIGHT with no same-cycle writeback, or the rd counter = 3.
REQ-018 SHALL deassert issue_ready while flush = 1.
REQ-019 SHALL increment the rd counter and inflight on issue_valid & issue_ready & issue_rd_we & issue_rd != 0.
REQ-020 SHALL decrement the wb_rd counter and inflight on wb_valid when the wb_rd counter is non-zero.
REQ-021 SHALL leave the counter and inflight unchanged when REQ-019 and REQ-020 hit the same register in the same cycle; for different registers, both counters update and inflight is unchanged.
REQ-022 SHALL, on wb_valid with wb_rd != 0 and a zero counter, ignore the writeback (no underflow) and assert wb_err for exactly the next cycle.
REQ-023 SHALL zero all counters and inflight on the cycle after flush = 1; flush has priority over simultaneous issue and writeback.
REQ-024 SHALL increment stall_cnt by 1 each cycle that issue_valid = 1 and issue_ready = 0; it wraps at 2^32 and is not cleared by flush.
REQ-025 SHALL drive issue_ready from combinational logic with zero-cycle latency; forward outputs are 0 when not selected, and fwd_data is 0 when neither select is 1.

Reset
REQ-026 SHALL set all counters, inflight, stall_cnt, and wb_err to 0 on reset.
REQ-027 SHALL hold issue_ready = 1 during reset when issue_valid is asserted with no hazard; reset mid-operation discards all pending state without raising wb_err.

Structure
REQ-028 SHALL place REG_WIDTH and a scoreboard_cnt_t 2-bit typedef in ysyx_24080006_pkg.
REQ-029 SHALL be a single module with no sub-modules; the pending-counter array is a flat register vector.

Verification
REQ-030 SHALL cover: issue rd=5, then next cycle issue rs1=5 with no writeback -> issue_ready = 0, stall_cnt increments by 1 per cycle.
REQ-031 SHALL cover: counter[5] = 1, wb_valid with wb_rd = 5 and wb_data = 0xDEADBEEF, same-cycle issue with rs2 = 5 -> issue_ready = 1, fwd_rs2_en = 1, fwd_data = 0xDEADBEEF.
REQ-032 SHALL cover: three issues to rd = 1, 2, 3 -> inflight = 3; a fourth issue to rd = 4 is stalled until a writeback arrives in the same cycle, then accepted with inflight = 3.
REQ-033 SHALL cover: flush with inflight = 2, then wb_valid with wb_rd = 1 -> counters 0, inflight 0, wb_err = 1 for one cycle.
REQ-034 SHALL cover: issue with rs1 = 0 and rd = 0 while pending state is arbitrary -> issue_ready = 1 and no counter change.
